// File: rtl/mips_pkg.sv
// =============================================================================
// Module : mips_pkg
// Brief  : Shared MIPS field widths, bit positions, opcodes and fetch states.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mips_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/instr_fields.sv
// =============================================================================
// Module : instr_fields
// Brief  : Combinational split of a 32-bit MIPS word into its decode fields.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module instr_fields
    import mips_pkg::*;
(
    input  logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [IMM_W-1:0]    imm
);

    assign opcode = instr[OPCODE_LSB +: OPCODE_W];
    assign rs     = instr[RS_LSB     +: REG_W];
    assign rt     = instr[RT_LSB     +: REG_W];
    assign rd     = instr[RD_LSB     +: REG_W];
    assign shamt  = instr[SHAMT_LSB  +: SHAMT_W];
    assign funct  = instr[FUNCT_LSB  +: FUNCT_W];
    assign imm    = instr[IMM_LSB    +: IMM_W];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// =============================================================================
// Module : fetch_unit
// Brief  : Single-outstanding instruction fetch stage with redirect handling.
//          Optional counters enabled by defining FETCH_PERF_EN.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [OPCODE_W-1:0] id_opcode,
    output logic [REG_W-1:0]    id_rs,
    output logic [REG_W-1:0]    id_rt,
    output logic [REG_W-1:0]    id_rd,
    output logic [SHAMT_W-1:0]  id_shamt,
    output logic [FUNCT_W-1:0]  id_funct,
    output logic [IMM_W-1:0]    id_imm,
    output logic [ADDR_W-1:0]   id_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_killed
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [ADDR_W-1:0] r_pc4;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;
    logic              w_rsp_take;
    logic              w_unused_tgt_lsb;

    assign w_pc_inc         = r_pc + ADDR_W'(4);
    assign w_target         = {br_target[ADDR_W-1:2], 2'b00};
    assign w_unused_tgt_lsb = ^br_target[1:0];
    // A response coinciding with a redirect belongs to the old path.
    assign w_rsp_take       = (r_state == ST_WAIT) && imem_rsp_valid && !br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_FETCH;
            ST_FETCH: if (imem_req_ready) w_state_nxt = br_taken ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (br_taken)            w_state_nxt = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
                else if (imem_rsp_valid) w_state_nxt = ST_HOLD;
            end
            ST_HOLD:  if (br_taken || id_ready) w_state_nxt = ST_FETCH;
            ST_DRAIN: if (imem_rsp_valid) w_state_nxt = ST_FETCH;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == ST_FETCH);
        id_valid       = (r_state == ST_HOLD) && !br_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_pc4 <= '0;
        end else begin
            if (br_taken) begin
                r_pc <= w_target;
            end else if (w_rsp_take) begin
                r_pc <= w_pc_inc;
            end
            if (w_rsp_take) begin
                r_ir  <= imem_rsp_data;
                r_pc4 <= w_pc_inc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign id_pc4    = r_pc4;

    instr_fields u_fields (
        .instr  (r_ir),
        .opcode (id_opcode),
        .rs     (id_rs),
        .rt     (id_rt),
        .rd     (id_rd),
        .shamt  (id_shamt),
        .funct  (id_funct),
        .imm    (id_imm)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_killed;
    logic        w_kill;

    assign w_kill = ((r_state == ST_WAIT)  && imem_rsp_valid && br_taken) ||
                    ((r_state == ST_DRAIN) && imem_rsp_valid) ||
                    ((r_state == ST_HOLD)  && br_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_killed  <= '0;
        end else begin
            if (id_valid && id_ready) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_kill)               r_perf_killed  <= r_perf_killed + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_killed  = r_perf_killed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// =============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit (two RESET_PC builds).
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;

    logic        imem_req_valid, id_valid;
    logic [31:0] imem_addr, id_pc4;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;

    logic        w2_req_valid, w2_id_valid;
    logic [31:0] w2_addr, w2_pc4;
    logic [5:0]  w2_opcode, w2_funct;
    logic [4:0]  w2_rs, w2_rt, w2_rd, w2_shamt;
    logic [15:0] w2_imm;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_killed, w2_perf_fetched, w2_perf_killed;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        pend;
    logic [31:0] pend_data;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .br_taken(br_taken), .br_target(br_target),
        .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_funct(id_funct), .id_imm(id_imm), .id_pc4(id_pc4)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w2_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(w2_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .br_taken(br_taken), .br_target(br_target),
        .id_valid(w2_id_valid), .id_ready(id_ready), .id_opcode(w2_opcode),
        .id_rs(w2_rs), .id_rt(w2_rt), .id_rd(w2_rd), .id_shamt(w2_shamt),
        .id_funct(w2_funct), .id_imm(w2_imm), .id_pc4(w2_pc4)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w2_perf_fetched), .perf_killed(w2_perf_killed)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: word_at = 32'h012A_4020;
            32'h0000_0004: word_at = 32'h8D09_0004;
            32'h0000_0100: word_at = 32'h0800_0040;
            default:       word_at = 32'h0000_0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: answers in the cycle after acceptance.
    task automatic drive_mem();
        imem_req_ready = 1'b1;
        imem_rsp_valid = pend;
        imem_rsp_data  = pend ? pend_data : 32'h0;
        #1;
    endtask

    task automatic advance();
        logic        nxt_pend;
        logic [31:0] nxt_data;
        nxt_pend = imem_req_valid && imem_req_ready;
        nxt_data = word_at(imem_addr);
        step();
        pend      = nxt_pend;
        pend_data = nxt_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; pend = 1'b0;
        step(); step();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        n_checks++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", id_pc4); end
        n_checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== 32'h0) begin n_fail++; $display("FAIL reset_fields: got nonzero opcode %h", id_opcode); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        n_checks++; if (w2_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_addr_wrap: got %h expected fffffffc", w2_addr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'h0 || perf_killed !== 32'h0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_killed); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        drive_mem();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b expected 0", imem_req_valid); end
        advance(); drive_mem();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_addr); end
        advance(); drive_mem();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wait_id_valid: got %b expected 0", id_valid); end
        advance(); drive_mem();
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL cycle4_id_valid: got %b expected 1", id_valid); end
        n_checks++; if (id_opcode !== 6'h00 || id_rs !== 5'd9 || id_rt !== 5'd10 || id_rd !== 5'd8) begin n_fail++; $display("FAIL first_fields: got op=%h rs=%0d rt=%0d rd=%0d expected 0/9/10/8", id_opcode, id_rs, id_rt, id_rd); end
        n_checks++; if (id_shamt !== 5'd0 || id_funct !== 6'h20 || id_imm !== 16'h4020) begin n_fail++; $display("FAIL first_low_fields: got sh=%0d fn=%h imm=%h expected 0/20/4020", id_shamt, id_funct, id_imm); end
        n_checks++; if (id_pc4 !== 32'h4) begin n_fail++; $display("FAIL first_pc4: got %h expected 4", id_pc4); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            advance(); drive_mem();
            n_checks++; if (id_valid !== 1'b1 || id_rd !== 5'd8 || id_funct !== 6'h20 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_stable[%0d]: got v=%b rd=%0d fn=%h req=%b expected 1/8/20/0", i, id_valid, id_rd, id_funct, imem_req_valid); end
        end
        id_ready = 1'b1; #1;
        advance(); id_ready = 1'b0; drive_mem();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || id_valid !== 1'b0) begin n_fail++; $display("FAIL second_req: got v=%b a=%h idv=%b expected 1/4/0", imem_req_valid, imem_addr, id_valid); end
        advance(); drive_mem();
        advance(); drive_mem();
        n_checks++; if (id_valid !== 1'b1 || id_opcode !== 6'h23 || id_rs !== 5'd8 || id_rt !== 5'd9 || id_imm !== 16'h0004) begin n_fail++; $display("FAIL lw_fields: got v=%b op=%h rs=%0d rt=%0d imm=%h expected 1/23/8/9/0004", id_valid, id_opcode, id_rs, id_rt, id_imm); end
        n_checks++; if (id_pc4 !== 32'h8) begin n_fail++; $display("FAIL lw_pc4: got %h expected 8", id_pc4); end
        id_ready = 1'b1; #1;
        advance(); id_ready = 1'b0;
    endtask

    task automatic test_branch_in_wait();
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL third_req: got v=%b a=%h expected 1/8", imem_req_valid, imem_addr); end
        step();
        imem_req_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0103; #1;
        n_checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL br_wait_outputs: got idv=%b req=%b expected 0/0", id_valid, imem_req_valid); end
        step();
        br_taken = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_req: got %b expected 0", imem_req_valid); end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_drop: got id_valid %b expected 0", id_valid); end
        step();
        imem_rsp_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_req: got v=%b a=%h idv=%b expected 1/100/0", imem_req_valid, imem_addr, id_valid); end
        pend = 1'b0;
        drive_mem(); advance(); drive_mem(); advance(); drive_mem();
        n_checks++; if (id_valid !== 1'b1 || id_opcode !== 6'h02 || id_pc4 !== 32'h104) begin n_fail++; $display("FAIL target_word: got v=%b op=%h pc4=%h expected 1/02/104", id_valid, id_opcode, id_pc4); end
    endtask

    task automatic test_branch_in_hold();
        id_ready = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200; #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL hold_kill_mask: got id_valid %b expected 0", id_valid); end
        step();
        id_ready = 1'b0; br_taken = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL hold_kill_req: got v=%b a=%h expected 1/200", imem_req_valid, imem_addr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd2 || perf_killed !== 32'd2) begin n_fail++; $display("FAIL perf_after_hold_kill: got %0d/%0d expected 2/2", perf_fetched, perf_killed); end
`endif
        br_taken = 1'b1; br_target = 32'h0000_0307; #1;
        step();
        br_taken = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h304) begin n_fail++; $display("FAIL fetch_redirect_noacc: got v=%b a=%h expected 1/304", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0400; #1;
        step();
        imem_req_ready = 1'b0; br_taken = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_redirect_acc_drain: got req %b expected 0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0; #1;
        step();
        imem_rsp_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h400 || id_valid !== 1'b0) begin n_fail++; $display("FAIL after_drain_req: got v=%b a=%h idv=%b expected 1/400/0", imem_req_valid, imem_addr, id_valid); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd2 || perf_killed !== 32'd3) begin n_fail++; $display("FAIL perf_final: got %0d/%0d expected 2/3", perf_fetched, perf_killed); end
`endif
    endtask

    task automatic test_reset_pc_wrap();
        rst = 1'b1; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; pend = 1'b0;
        step(); step();
        rst = 1'b0;
        drive_mem(); advance(); drive_mem();
        n_checks++; if (w2_req_valid !== 1'b1 || w2_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_req: got v=%b a=%h expected 1/fffffffc", w2_req_valid, w2_addr); end
        advance(); drive_mem(); advance(); drive_mem();
        n_checks++; if (w2_id_valid !== 1'b1 || w2_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got v=%b pc4=%h expected 1/0", w2_id_valid, w2_pc4); end
        id_ready = 1'b1; #1;
        advance(); id_ready = 1'b0; drive_mem();
        n_checks++; if (w2_req_valid !== 1'b1 || w2_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_second_req: got v=%b a=%h expected 1/0", w2_req_valid, w2_addr); end
    endtask

    task automatic test_reset_in_wait();
        rst = 1'b1; imem_rsp_valid = 1'b0; pend = 1'b0;
        step(); step();
        rst = 1'b0;
        drive_mem(); advance(); drive_mem(); advance();
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF; #1;
        step();
        rst = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_wait_ctrl: got req=%b idv=%b pc4=%h expected 0/0/0", imem_req_valid, id_valid, id_pc4); end
        n_checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== 32'h0 || id_imm !== 16'h0) begin n_fail++; $display("FAIL rst_wait_fields: got op=%h imm=%h expected 0/0", id_opcode, id_imm); end
        step();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_next_req: got v=%b a=%h idv=%b expected 1/0/0", imem_req_valid, imem_addr, id_valid); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd0 || perf_killed !== 32'd0) begin n_fail++; $display("FAIL rst_wait_perf: got %0d/%0d expected 0/0", perf_fetched, perf_killed); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_branch_in_wait();
        test_branch_in_hold();
        test_reset_pc_wrap();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Produces the instruction word whose opcode field drives the main control decoder.
- Holds the PC and issues one word request at a time to instruction memory over a valid/ready request and response handshake.
- Registers the returned word and presents it to decode with a valid/ready handshake, split into MIPS fields.
- Handles branch/jump redirects, including killing the request currently in flight.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  request to fetch the word at imem_addr
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_addr  out  ADDR_W  word-aligned fetch address; bits [1:0] are always 0
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  instruction word
- br_taken  in  1  redirect strobe from the execute stage
- br_target  in  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts the instruction
- id_opcode  out  6  instr[31:26]
- id_rs  out  5  instr[25:21]
- id_rt  out  5  instr[20:16]
- id_rd  out  5  instr[15:11]
- id_shamt  out  5  instr[10:6]
- id_funct  out  6  instr[5:0]
- id_imm  out  16  instr[15:0]
- id_pc4  out  ADDR_W  address of the held instruction + 4

Behaviour:
- States: IDLE, FETCH, WAIT, HOLD, DRAIN. Reset puts the block in IDLE.
- Reset values: pc = RESET_PC, IR = 0, id_pc4 = 0, all valid outputs 0. Reset mid-transaction discards any outstanding response. Memory must tolerate one orphaned response after reset.
- IDLE:
  - Always moves to FETCH on the next cycle.
  - imem_req_valid = 0.
- FETCH:
  - imem_req_valid = 1 and imem_addr = pc.
  - On imem_req_ready, go to WAIT.
  - While not accepted, the address may change only because of a redirect.
- WAIT:
  - On imem_rsp_valid: IR <= rsp_data, id_pc4 <= pc+4, pc <= pc+4, go to HOLD.
  - imem_rsp_valid is ignored in every state except WAIT and DRAIN.
- HOLD:
  - id_valid = 1 & !br_taken, computed combinationally.
  - On id_valid & id_ready, go to FETCH.
  - Field outputs are stable for the whole time in HOLD.
- Throughput: 3 cycles per instruction with zero-wait memory (FETCH, WAIT, HOLD). Latency from response to id_valid is 1 cycle.
- PC arithmetic: modulo 2^ADDR_W, so 0xFFFF_FFFC + 4 = 0x0000_0000 with no flag.
- Redirect (br_taken=1) has priority over every handshake and sets pc <= {br_target[ADDR_W-1:2], 2'b00}. Effect by state:
  - FETCH, request accepted in the same cycle: the request carried the old address, so go to DRAIN.
  - FETCH, request not accepted: stay in FETCH; the new address is presented next cycle.
  - WAIT without a response: go to DRAIN.
  - WAIT with a response in the same cycle: discard the response and go to FETCH.
  - HOLD: the instruction is killed. id_valid is masked that cycle, so an id_ready in that cycle is not a transfer. Go to FETCH.
  - DRAIN: update pc again and stay in DRAIN.
  - IDLE: update pc only.
- DRAIN: wait for imem_rsp_valid, discard the data, go to FETCH. Exactly one outstanding request exists at any time.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetched (32 bits): increments on each id_valid & id_ready.
  - perf_killed (32 bits): increments on each discarded response or killed HOLD instruction.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - field width constants: OPCODE_W=6, REG_W=5, FUNCT_W=6, IMM_W=16
  - field bit-position constants
  - the fetch_state_t enum
  - opcode localparams such as OP_RTYPE=6'b000000, shared with the control decoder
- One natural sub-module: instr_fields. It is purely combinational, splits a 32-bit word into the id_* fields, and is reused by later decode-side blocks.

Test Plan:
- Reset then zero-wait memory returning 32'h012A4020 at addr 0: id_valid on cycle 4 after reset release, with id_opcode=0, rs=9, rt=10, rd=8, funct=6'h20, id_pc4=4. Next request addr=4.
- id_ready held low for 5 cycles in HOLD: fields stable, no new imem request. id_ready=1 then gives exactly one transfer and a FETCH of the next word.
- br_taken with target 32'h0000_0103 while in WAIT, response 2 cycles later: that response is dropped and never reaches id_valid. Next imem_addr=32'h0000_0100.
- br_taken and id_ready together in HOLD: no transfer counted. Next fetch is at br_target. With FETCH_PERF_EN defined, perf_killed=1 and perf_fetched unchanged.
- RESET_PC=32'hFFFF_FFFC: first fetch at 0xFFFF_FFFC with id_pc4=0, second fetch at 0x0000_0000.
- rst asserted in WAIT with a response arriving in the same cycle: after release all outputs are 0 and the next request is at RESET_PC.
